dut_initiator: RTL and testbench
================================

Name: dut_initiator

Overview:
- Bus initiator that drives the dut write/read method ports. It is the requester side of the EN/RDY method interface.
- Accepts one command at a time from a host-side valid/ready channel.
- Issues each command as a write or read method call, gated by the dut's RDY.
- Returns exactly one response per command: read data, or completion/timeout status.
- Used as the stimulus engine in front of dut in block-level and system benches.

Parameters:
ADDR_W, 3, address width of write_address/read_address/cmd_addr
DATA_W, 1, data width of write_data/read_data/cmd_wdata/rsp_rdata
TIMEOUT, 16, max cycles spent waiting for RDY before abort; 0 disables the timeout
CNT_W, 8, timeout counter width; must hold TIMEOUT

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous reset, active-high
cmd_valid  in  1  host command valid
cmd_ready  out  1  initiator can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_timeout  out  1  command aborted, RDY never seen
write_address  out  ADDR_W  to dut
write_data  out  DATA_W  to dut
write_en  out  1  to dut, write method enable
write_rdy  in  1  from dut
read_address  out  ADDR_W  to dut
read_en  out  1  to dut, read method enable
read_data  in  DATA_W  from dut, valid in the read_en cycle
read_rdy  in  1  from dut
busy  out  1  state != IDLE

Behaviour:
- Reset (RST high, async):
  - state = IDLE, timeout counter = 0.
  - Command and response registers cleared.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_timeout=0, write_en=0, read_en=0, write_address=0, read_address=0, write_data=0, busy=0.
- States: IDLE, WR, RD, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: latch cmd_write/addr/wdata, clear the counter, go to WR if cmd_write, else RD.
- Address and data outputs:
  - write_address/read_address are driven from the latched address.
  - write_data is driven from the latched wdata.
  - They are stable for the whole command and hold their value in IDLE.
- WR:
  - write_en = write_rdy (combinational; EN is never asserted while RDY=0).
  - Edge with write_rdy=1: write completes, go to RESP with rsp_write=1, rsp_rdata=0, rsp_timeout=0.
- RD:
  - read_en = read_rdy.
  - Edge with read_rdy=1: capture read_data into rsp_rdata, go to RESP with rsp_write=0, rsp_timeout=0.
- Timeout (WR/RD, TIMEOUT>0):
  - Counter increments on each edge with RDY=0.
  - When the counter equals TIMEOUT-1 and RDY is still 0: go to RESP with rsp_timeout=1, rsp_rdata=0. No EN is ever asserted for that command.
  - If RDY=1 on that same edge, completion wins and there is no timeout.
  - With TIMEOUT=0 the initiator waits indefinitely.
- RESP:
  - rsp_valid=1 and all rsp_* fields held stable until rsp_ready.
  - On the rsp_ready edge, go to IDLE.
  - No new command is accepted in this cycle (cmd_ready=0).
- Latency: with no stalls, cmd accept edge N → EN cycle N+1 → rsp_valid from cycle N+2. Minimum 3 cycles per command.
- Exactly one method enable per command. write_en and read_en are never high together.
- Reset mid-operation aborts the command immediately. There is no response, EN drops asynchronously, and the state returns to IDLE.
- The counter saturates and never wraps.

Test Plan:
- Write addr=5 data=1 with write_rdy=1, then read addr=5 with read_rdy=1 and read_data=1 → write_en pulses 1 cycle with write_address=5 and write_data=1; the first response has rsp_write=1. read_en pulses 1 cycle with read_address=5; the second response has rsp_rdata=1 and rsp_timeout=0. Each command takes 3 cycles.
- Read addr=2 with read_rdy held 0 for 5 cycles, then 1, read_data=0 → read_en stays low for 5 cycles, pulses once, then rsp_rdata=0 and rsp_timeout=0.
- TIMEOUT=16, write with write_rdy stuck 0 → write_en is never asserted, and rsp_valid with rsp_timeout=1 appears 16 cycles after entering WR. busy=1 throughout.
- Response backpressure: read completes, rsp_ready held 0 for 4 cycles → rsp_valid and rsp_rdata stay stable, cmd_ready=0, and no second EN occurs.
- RST pulsed high while in RD with read_rdy=0 → read_en=0, cmd_ready=1, rsp_valid=0 and busy=0 immediately; the next command completes normally.
- TIMEOUT=0, read_rdy=0 for 100 cycles then 1 → no timeout; the read completes with the correct data.

Source files
------------

// File: rtl/dut_initiator.sv
// Requester side of the dut EN/RDY method interface: takes one host command at a time,
// issues it as a single write or read method call and returns exactly one response.
module dut_initiator #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 1,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              write_en,
   input  logic              write_rdy,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_rdy,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_cnt_next;
   logic              latch_cmd;
   logic              rsp_write_q;
   logic              rsp_write_next;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic [DATA_W-1:0] rsp_rdata_next;
   logic              rsp_timeout_q;
   logic              rsp_timeout_next;

   // State, command latch, wait counter and response registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wait_cnt      <= '0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state         <= state_next;
         wait_cnt      <= wait_cnt_next;
         rsp_write_q   <= rsp_write_next;
         rsp_rdata_q   <= rsp_rdata_next;
         rsp_timeout_q <= rsp_timeout_next;
         if (latch_cmd) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
         end
      end
   end

   // Next state and method enables; EN simply follows RDY while waiting, so it can
   // never be raised without RDY and fires on exactly the completing edge.
   always_comb begin
      state_next       = state;
      wait_cnt_next    = wait_cnt;
      latch_cmd        = 1'b0;
      rsp_write_next   = rsp_write_q;
      rsp_rdata_next   = rsp_rdata_q;
      rsp_timeout_next = rsp_timeout_q;
      cmd_ready        = 1'b0;
      rsp_valid        = 1'b0;
      write_en         = 1'b0;
      read_en          = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               latch_cmd     = 1'b1;
               wait_cnt_next = '0;
               state_next    = cmd_write ? WR : RD;
            end
         end
         WR: begin
            write_en = write_rdy;
            if (write_rdy) begin
               state_next       = RESP;
               rsp_write_next   = 1'b1;
               rsp_rdata_next   = '0;
               rsp_timeout_next = 1'b0;
            end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST)) begin
               state_next       = RESP;
               rsp_write_next   = 1'b1;
               rsp_rdata_next   = '0;
               rsp_timeout_next = 1'b1;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_next = wait_cnt + CNT_W'(1);
            end
         end
         RD: begin
            read_en = read_rdy;
            if (read_rdy) begin
               state_next       = RESP;
               rsp_write_next   = 1'b0;
               rsp_rdata_next   = read_data;
               rsp_timeout_next = 1'b0;
            end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LAST)) begin
               state_next       = RESP;
               rsp_write_next   = 1'b0;
               rsp_rdata_next   = '0;
               rsp_timeout_next = 1'b1;
            end else if (wait_cnt != CNT_MAX) begin
               wait_cnt_next = wait_cnt + CNT_W'(1);
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign write_address = addr_q;
   assign read_address  = addr_q;
   assign write_data    = wdata_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign busy          = (state != IDLE);

   a_one_enable : assert property (@(posedge CLK) disable iff (RST) !(write_en && read_en));
   a_rsp_hold : assert property (@(posedge CLK) disable iff (RST)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_write) && $stable(rsp_rdata)
                                     && $stable(rsp_timeout)));

endmodule

// File: tb/tb_dut_initiator.sv
// Bench for dut_initiator: a TIMEOUT=16 and a TIMEOUT=0 instance share one host driver,
// backed by a slave memory and checked against a command-level reference model.
module tb_dut_initiator;

   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 1;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 8;

   logic CLK = 1'b0;
   logic RST;
   logic sel;
   logic cmd_valid;
   logic cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic rsp_ready;
   logic write_rdy;
   logic read_rdy;

   logic [1:0] cmd_valid_v, cmd_ready_v, rsp_valid_v, rsp_ready_v, rsp_write_v, rsp_timeout_v;
   logic [1:0] write_en_v, read_en_v, busy_v;
   logic [1:0][DATA_W-1:0] rsp_rdata_v, write_data_v, read_data_v;
   logic [1:0][ADDR_W-1:0] write_address_v, read_address_v;

   logic [DATA_W-1:0] slave_mem [2**ADDR_W];
   logic [DATA_W-1:0] ref_mem [2**ADDR_W];

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign cmd_valid_v[g] = cmd_valid & (sel == g[0]);
      assign rsp_ready_v[g] = rsp_ready & (sel == g[0]);
      assign read_data_v[g] = slave_mem[read_address_v[g]];

      dut_initiator #(
         .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT((g == 0) ? TIMEOUT : 0), .CNT_W(CNT_W)
      ) u_dut (
         .CLK(CLK), .RST(RST),
         .cmd_valid(cmd_valid_v[g]), .cmd_ready(cmd_ready_v[g]), .cmd_write(cmd_write),
         .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
         .rsp_valid(rsp_valid_v[g]), .rsp_ready(rsp_ready_v[g]), .rsp_write(rsp_write_v[g]),
         .rsp_rdata(rsp_rdata_v[g]), .rsp_timeout(rsp_timeout_v[g]),
         .write_address(write_address_v[g]), .write_data(write_data_v[g]),
         .write_en(write_en_v[g]), .write_rdy(write_rdy),
         .read_address(read_address_v[g]), .read_en(read_en_v[g]),
         .read_data(read_data_v[g]), .read_rdy(read_rdy), .busy(busy_v[g])
      );
   end

   // The slave memory commits a write only when a write method actually fires.
   always @(posedge CLK) begin
      for (int g = 0; g < 2; g++) begin
         if (write_en_v[g]) slave_mem[write_address_v[g]] <= write_data_v[g];
      end
   end

   typedef struct {
      bit          s;
      bit          write;
      logic [2:0]  addr;
      logic [0:0]  wdata;
      int          delay;
      int          stall;
      bit          exp_timeout;
      logic [0:0]  exp_rdata;
      int          exp_wait;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one command with RDY held low for 'delay' wait cycles and the response
   // back-pressured for 'stall' cycles; starts and ends at a falling edge.
   task automatic applyStimulus(input bit s, input bit write, input logic [2:0] addr,
                                input logic [0:0] wdata, input int delay, input int stall,
                                input bit exp_timeout, input logic [0:0] exp_rdata,
                                input int exp_wait, input string tag);
      int wait_cycles = 0;
      int en_count = 0;
      bit wrong_en = 0;
      bit addr_bad = 0;
      bit busy_bad = 0;
      bit stall_bad = 0;
      logic rw, rt;
      logic [0:0] rd;
      sel = s;
      cmd_valid = 1'b1;
      cmd_write = write;
      cmd_addr = addr;
      cmd_wdata = wdata;
      write_rdy = 1'b0;
      read_rdy = 1'b0;
      rsp_ready = 1'b0;
      checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready_v[sel]), 32'd1);
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      cmd_addr = 3'($urandom);
      cmd_wdata = 1'($urandom);
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (write) write_rdy = (cyc >= delay);
         else read_rdy = (cyc >= delay);
         @(negedge CLK);
         wait_cycles++;
         if (!busy_v[sel]) busy_bad = 1;
         if (write_en_v[sel] || read_en_v[sel]) en_count++;
         if ((write_en_v[sel] && !write) || (read_en_v[sel] && write)) wrong_en = 1;
         if (write_address_v[sel] !== addr || read_address_v[sel] !== addr) addr_bad = 1;
         if (write && write_data_v[sel] !== wdata) addr_bad = 1;
         @(posedge CLK); #1;
         if (rsp_valid_v[sel]) break;
      end
      write_rdy = 1'b0;
      read_rdy = 1'b0;
      checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid_v[sel]), 32'd1);
      checkOutput({tag, ".wait_cycles"}, 32'(wait_cycles), 32'(exp_wait));
      checkOutput({tag, ".en_count"}, 32'(en_count), exp_timeout ? 32'd0 : 32'd1);
      checkOutput({tag, ".en_kind_ok"}, 32'(wrong_en), 32'd0);
      checkOutput({tag, ".addr_data_stable"}, 32'(addr_bad), 32'd0);
      checkOutput({tag, ".busy_while_waiting"}, 32'(busy_bad), 32'd0);
      checkOutput({tag, ".rsp_write"}, 32'(rsp_write_v[sel]), 32'(write));
      checkOutput({tag, ".rsp_rdata"}, 32'(rsp_rdata_v[sel]), 32'(exp_rdata));
      checkOutput({tag, ".rsp_timeout"}, 32'(rsp_timeout_v[sel]), 32'(exp_timeout));
      rw = rsp_write_v[sel];
      rd = rsp_rdata_v[sel];
      rt = rsp_timeout_v[sel];
      for (int i = 0; i < stall; i++) begin
         cmd_valid = 1'b1;
         cmd_write = 1'($urandom);
         write_rdy = 1'b1;
         read_rdy = 1'b1;
         @(negedge CLK);
         if (!rsp_valid_v[sel] || rsp_write_v[sel] !== rw || rsp_rdata_v[sel] !== rd ||
             rsp_timeout_v[sel] !== rt || cmd_ready_v[sel] || write_en_v[sel] ||
             read_en_v[sel]) stall_bad = 1;
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      cmd_valid = 1'b0;
      write_rdy = 1'b0;
      read_rdy = 1'b0;
      rsp_ready = 1'b1;
      if (!rsp_valid_v[sel] || cmd_ready_v[sel] || rsp_rdata_v[sel] !== rd) stall_bad = 1;
      checkOutput({tag, ".rsp_hold"}, 32'(stall_bad), 32'd0);
      @(posedge CLK); #1;
      rsp_ready = 1'b0;
      checkOutput({tag, ".back_to_idle"},
                  32'({rsp_valid_v[sel], cmd_ready_v[sel], busy_v[sel]}), 32'b010);
      @(negedge CLK);
      if (write && !exp_timeout) ref_mem[addr] = wdata;
   endtask

   vec_t vecs [13];

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
         slave_mem[i] = '0;
         ref_mem[i] = '0;
      end
      vecs[0]  = '{0, 1, 3'd5, 1'b1,   0, 0, 0, 1'b0,   1};
      vecs[1]  = '{0, 0, 3'd5, 1'b0,   0, 0, 0, 1'b1,   1};
      vecs[2]  = '{0, 0, 3'd2, 1'b0,   5, 0, 0, 1'b0,   6};
      vecs[3]  = '{0, 1, 3'd7, 1'b1,  16, 0, 1, 1'b0,  16};
      vecs[4]  = '{0, 0, 3'd7, 1'b0,   0, 0, 0, 1'b0,   1};
      vecs[5]  = '{0, 0, 3'd5, 1'b0,   0, 4, 0, 1'b1,   1};
      vecs[6]  = '{0, 1, 3'd3, 1'b1,  15, 0, 0, 1'b0,  16};
      vecs[7]  = '{0, 0, 3'd3, 1'b0,  15, 0, 0, 1'b1,  16};
      vecs[8]  = '{0, 0, 3'd4, 1'b0,  30, 0, 1, 1'b0,  16};
      vecs[9]  = '{1, 1, 3'd6, 1'b1,  40, 0, 0, 1'b0,  41};
      vecs[10] = '{1, 0, 3'd6, 1'b0, 100, 0, 0, 1'b1, 101};
      vecs[11] = '{0, 1, 3'd5, 1'b0,   2, 1, 0, 1'b0,   3};
      vecs[12] = '{0, 0, 3'd5, 1'b0,   1, 2, 0, 1'b0,   2};

      RST = 1'b1;
      sel = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      write_rdy = 1'b0;
      read_rdy = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("reset.cmd_ready", 32'(cmd_ready_v[0]), 32'd1);
      checkOutput("reset.rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
      checkOutput("reset.rsp_write", 32'(rsp_write_v[0]), 32'd0);
      checkOutput("reset.rsp_rdata", 32'(rsp_rdata_v[0]), 32'd0);
      checkOutput("reset.rsp_timeout", 32'(rsp_timeout_v[0]), 32'd0);
      checkOutput("reset.enables", 32'({write_en_v[0], read_en_v[0]}), 32'd0);
      checkOutput("reset.addresses", 32'({write_address_v[0], read_address_v[0]}), 32'd0);
      checkOutput("reset.write_data", 32'(write_data_v[0]), 32'd0);
      checkOutput("reset.busy", 32'(busy_v), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].s, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                       vecs[i].stall, vecs[i].exp_timeout, vecs[i].exp_rdata,
                       vecs[i].exp_wait, $sformatf("vec%0d", i));
      end

      // Reset while a read waits on RDY: the command vanishes without a response.
      sel = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr = 3'd2;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("midrd.busy_before", 32'(busy_v[0]), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("midrd.read_en", 32'(read_en_v[0]), 32'd0);
      checkOutput("midrd.cmd_ready", 32'(cmd_ready_v[0]), 32'd1);
      checkOutput("midrd.rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
      checkOutput("midrd.busy", 32'(busy_v[0]), 32'd0);
      checkOutput("midrd.read_address", 32'(read_address_v[0]), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      applyStimulus(0, 0, 3'd6, 1'b0, 0, 0, 0, ref_mem[6], 1, "after_reset");

      // Random commands against the reference model: a command times out only on the
      // TIMEOUT instance when RDY stays low for at least TIMEOUT wait cycles.
      for (int n = 0; n < 40; n++) begin
         bit s, w, to;
         logic [2:0] a;
         logic [0:0] d;
         int dly, stl;
         s = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = 3'($urandom);
         d = 1'($urandom);
         dly = (n % 8 == 0) ? 15 + (n % 16 == 0 ? 1 : 0) : $urandom_range(0, 20);
         stl = $urandom_range(0, 3);
         to = (s == 0) && (dly >= TIMEOUT);
         applyStimulus(s, w, a, d, dly, stl, to, (w || to) ? 1'b0 : ref_mem[a],
                       to ? TIMEOUT : dly + 1, $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
